ladner_fischer32: RTL and testbench
===================================

LADNER_FISCHER32 -- requirements
Module: ladner_fischer32

Interface
REQ-001: Parameter WIDTH, default 32, operand width; fixed at 32, other values unsupported.
REQ-002: Parameter LEVELS, default 5, prefix-tree depth, equal to log2(WIDTH).
REQ-003: clk  input  1  single clock, rising-edge active.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: a  input  32  addend A, unsigned.
REQ-006: b  input  32  addend B, unsigned.
REQ-007: cin  input  1  carry-in, weight 1.
REQ-008: s  output  32  registered sum bits [31:0].
REQ-009: cout  output  1  registered carry-out, weight 2^32.

Function
REQ-010: Every rising clk edge with rst_n high SHALL load {cout,s} with the 33-bit value a + b + cin, computed from a, b and cin sampled at that edge.
REQ-011: Latency SHALL be exactly one clock; there is no handshake, and a new operand set SHALL be accepted every cycle (throughput 1/clk).
REQ-012: The bit-level pre-processing SHALL be g[i] = a[i]&b[i] and p[i] = a[i]^b[i], for i = 0..31.
REQ-013: cin SHALL enter the prefix network as the position-(-1) generate term, so that c[0] = cin.
REQ-014: The carries SHALL be computed by a Ladner-Fischer parallel-prefix network of LEVELS = 5 levels.
REQ-015: Each prefix node SHALL apply the operator (G,P) o (G',P') = (G | P&G', P&P').
REQ-016: Nodes needing only the group generate SHALL be gray cells that omit the P output.
REQ-017: Prefix fan-out SHALL follow the Ladner-Fischer minimum-depth pattern: at level k, the odd-group span propagates to the following 2^(k-1) positions.
REQ-018: The sum SHALL be s[i] = p[i] ^ c[i].
REQ-019: cout SHALL be the group generate of bits 31..0 including cin; no ripple-carry chain longer than one cell per level is permitted.
REQ-020: Overflow SHALL wrap modulo 2^32 in s; the 33rd bit appears only in cout.
REQ-021: Input values between clock edges SHALL NOT affect the outputs; the outputs change only on a clk edge or on reset.

Reset
REQ-022: rst_n low SHALL force s = 32'h00000000 and cout = 0 immediately, without waiting for clk.
REQ-023: While rst_n is low, clk edges SHALL NOT update the outputs.
REQ-024: The first rising clk edge after rst_n deasserts SHALL load a + b + cin normally.
REQ-025: An assertion of rst_n in the middle of a run SHALL discard the in-flight result.

Structure
REQ-026: Constants WIDTH = 32 and LEVELS = 5 SHALL reside in the shared package ladner_fischer_pkg.
REQ-027: A single sub-module, lf_prefix_cell, SHALL implement the black/gray prefix operator, with a parameter selecting whether the P output is produced.
REQ-028: The prefix network SHALL be built with generate loops over levels and bits.
REQ-029: The output register SHALL be the only sequential logic in the block.

Verification
REQ-030: a=00000000, b=00000000, cin=0 -> one clock later {cout,s} = {0,00000000}.
REQ-031: a=FFFFFFFF, b=00000001, cin=0 -> {1,00000000}; a=FFFFFFFF, b=FFFFFFFF, cin=1 -> {1,FFFFFFFF}.
REQ-032: a=55555555, b=AAAAAAAA: cin=0 -> {0,FFFFFFFF}; cin=1 -> {1,00000000} (full carry propagation).
REQ-033: a=80000000, b=80000000, cin=0 -> {1,00000000}; a=12345678, b=9ABCDEF0, cin=0 -> {0,ACF13568}.
REQ-034: Apply every 8x8 pairing of {00000000, 00000001, 7FFFFFFF, 80000000, FFFFFFFF, 55555555, AAAAAAAA, 12345678}, each with cin=0 and cin=1 -> each result matches the 33-bit a+b+cin one clock later.
REQ-035: With cout=1 and s=FFFFFFFF held, drop rst_n between clock edges -> the outputs read 0 before the next edge and stay 0 until rst_n returns high.

Source files
------------

// File: rtl/ladner_fischer_pkg.sv
// ============================================================================
//  ladner_fischer_pkg : shared constants and index helper for the LF adder
//  Revision 1.0
// ============================================================================
`default_nettype none

package ladner_fischer_pkg;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  // Index of the right-hand (lower) operand feeding node i at level k
  function automatic int lf_lo_index(input int i, input int k);
    return ((i >> (k - 1)) << (k - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lf_prefix_cell.sv
// ============================================================================
//  lf_prefix_cell : (G,P) o (G',P') prefix operator, black or gray variant
//  Revision 1.0
// ============================================================================
`default_nettype none

module lf_prefix_cell #(
  parameter bit HAS_P = 1'b1
) (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);

  generate
    if (HAS_P) begin : g_black
      assign p_o = p_hi_i & p_lo_i;
    end else begin : g_gray
      // Group already reaches bit 0 / cin, so its propagate is never consumed
      assign p_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ladner_fischer32.sv
// ============================================================================
//  ladner_fischer32 : registered 32-bit adder, Ladner-Fischer carry network
//  Revision 1.0
// ============================================================================
`default_nettype none

module ladner_fischer32 #(
  parameter int WIDTH  = ladner_fischer_pkg::WIDTH,
  parameter int LEVELS = ladner_fischer_pkg::LEVELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  import ladner_fischer_pkg::*;

  logic [WIDTH-1:0] w_g [0:LEVELS];
  logic [WIDTH-1:0] w_p [0:LEVELS];
  logic [WIDTH-1:0] w_prop;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  assign w_prop = a ^ b;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
      if (i == 0) begin : g_cin
        // cin folded in as the position -1 generate term
        lf_prefix_cell #(.HAS_P(1'b0)) u_cell (
          .g_hi_i (a[0] & b[0]),
          .p_hi_i (w_prop[0]),
          .g_lo_i (cin),
          .p_lo_i (1'b0),
          .g_o    (w_g[0][0]),
          .p_o    (w_p[0][0])
        );
      end else begin : g_bit
        assign w_g[0][i] = a[i] & b[i];
        assign w_p[0][i] = w_prop[i];
      end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
        if (((i >> (k - 1)) % 2) == 1) begin : g_node
          localparam int J = lf_lo_index(i, k);
          lf_prefix_cell #(.HAS_P(i >= (1 << k))) u_cell (
            .g_hi_i (w_g[k-1][i]),
            .p_hi_i (w_p[k-1][i]),
            .g_lo_i (w_g[k-1][J]),
            .p_lo_i (w_p[k-1][J]),
            .g_o    (w_g[k][i]),
            .p_o    (w_p[k][i])
          );
        end else begin : g_pass
          assign w_g[k][i] = w_g[k-1][i];
          assign w_p[k][i] = w_p[k-1][i];
        end
      end
    end
  endgenerate

  assign w_carry = {w_g[LEVELS][WIDTH-2:0], cin};
  assign s_d     = w_prop ^ w_carry;
  assign cout_d  = w_g[LEVELS][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_ladner_fischer32.sv
// ============================================================================
//  tb_ladner_fischer32 : vector table + scoreboard bench for ladner_fischer32
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_ladner_fischer32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [32:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;

  int          n_tests;
  int          n_fail;
  vec_t        vecs[$];
  logic [32:0] sb[$];
  logic [31:0] ops[8];

  ladner_fischer32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {cout,s}=%0h required %0h", name, got, want);
    end
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  task automatic add_vec(input logic [31:0] x, input logic [31:0] y, input logic c, input logic [32:0] e);
    vec_t v;
    v.a = x; v.b = y; v.cin = c; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one operand set before the edge, compare one result after it
  task automatic stream_one(input vec_t v, input string name);
    logic [32:0] e;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, {cout, s}, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ops = '{32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000,
            32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA, 32'h12345678};

    add_vec(32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000);
    add_vec(32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000);
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
    add_vec(32'h55555555, 32'hAAAAAAAA, 1'b0, 33'h0_FFFFFFFF);
    add_vec(32'h55555555, 32'hAAAAAAAA, 1'b1, 33'h1_00000000);
    add_vec(32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);
    add_vec(32'h12345678, 32'h9ABCDEF0, 1'b0, 33'h0_ACF13568);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < 2; c++)
          add_vec(ops[i], ops[j], c[0], ref_add(ops[i], ops[j], c[0]));
    for (int r = 0; r < 100; r++) begin
      logic [31:0] x, y;
      logic        c;
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      add_vec(x, y, c, ref_add(x, y, c));
    end

    a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {cout, s}, 33'h0);

    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h00000001; b = 32'h00000002; cin = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", {cout, s}, 33'h0_00000004);

    for (int n = 0; n < vecs.size(); n++)
      stream_one(vecs[n], $sformatf("vec%0d", n));

    // Inputs toggling between edges must not disturb the held result
    stream_one(vecs[2], "hold_setup");
    #2; a = 32'h0; b = 32'h0; cin = 1'b0;
    #1;
    check("hold_mid_cycle", {cout, s}, 33'h1_FFFFFFFF);

    // Asynchronous reset between edges clears at once and holds
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", {cout, s}, 33'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_holds_over_edge", {cout, s}, 33'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reload_after_midrun_reset", {cout, s}, 33'h1_FFFFFFFF);

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
